// File: rtl/fir_xifu_pkg.sv
// Shared types, widths and helpers for the FIR XIFU coprocessor.
package fir_xifu_pkg;

    localparam int unsigned NB_REGS_DEFAULT = 32;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned X_ID_WIDTH      = 4;
    localparam int unsigned REG_FIELD_W     = 5;

    // INSTR_INVALID must stay all-zero so a reset ID/EX register decodes as a bubble.
    typedef enum logic [1:0] {
        INSTR_INVALID  = 2'b00,
        INSTR_XFIRLW   = 2'b01,
        INSTR_XFIRSW   = 2'b10,
        INSTR_XFIRDOTP = 2'b11
    } instr_t;

    typedef enum logic [1:0] {
        EX_IDLE     = 2'b00,
        EX_MEM_REQ  = 2'b01,
        EX_MEM_WAIT = 2'b10,
        EX_RESULT   = 2'b11
    } ex_state_t;

    typedef struct packed {
        instr_t                  instr;
        logic [XLEN-1:0]         base;
        logic [XLEN-1:0]         offset;
        logic [REG_FIELD_W-1:0]  rs1;
        logic [REG_FIELD_W-1:0]  rs2;
        logic [REG_FIELD_W-1:0]  rd;
        logic [X_ID_WIDTH-1:0]   id;
    } id2ex_t;

    typedef struct packed {
        logic commit;
        logic kill;
    } ctrl2ex_t;

    typedef struct packed {
        logic                  retire;
        logic [X_ID_WIDTH-1:0] id;
    } ex2ctrl_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       addr;
        logic                  we;
        logic [3:0]            be;
        logic [XLEN-1:0]       wdata;
    } x_mem_req_t;

    typedef struct packed {
        logic exc;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       rdata;
    } x_mem_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [XLEN-1:0]        data;
        logic [REG_FIELD_W-1:0] rd;
        logic                   we;
        logic                   exc;
    } x_result_t;

    // Sum of the two signed 16x16 lane products, wrapping modulo 2^32.
    // Low 32 bits of a product of sign-extended operands equal the signed product.
    function automatic logic [XLEN-1:0] dotp_prod(input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [XLEN-1:0] a_lo;
        logic [XLEN-1:0] a_hi;
        logic [XLEN-1:0] b_lo;
        logic [XLEN-1:0] b_hi;
        a_lo = {{16{a[15]}}, a[15:0]};
        a_hi = {{16{a[31]}}, a[31:16]};
        b_lo = {{16{b[15]}}, b[15:0]};
        b_hi = {{16{b[31]}}, b[31:16]};
        return XLEN'(a_lo * b_lo) + XLEN'(a_hi * b_hi);
    endfunction

endpackage

// File: rtl/cv32e40x_if_xif.sv
// Minimal XIF bundle: memory request/response, memory result and instruction result channels.
interface cv32e40x_if_xif;
    import fir_xifu_pkg::*;

    logic          mem_valid;
    logic          mem_ready;
    x_mem_req_t    mem_req;
    x_mem_resp_t   mem_resp;

    logic          mem_result_valid;
    x_mem_result_t mem_result;

    logic          result_valid;
    logic          result_ready;
    x_result_t     result;

    modport coproc_mem (
        output mem_valid,
        output mem_req,
        input  mem_ready,
        input  mem_resp
    );

    modport coproc_mem_result (
        input mem_result_valid,
        input mem_result
    );

    modport coproc_result (
        output result_valid,
        output result,
        input  result_ready
    );
endinterface

// File: rtl/fir_xifu_regfile.sv
// XIFU register file: two combinational read ports, one synchronous write port.
module fir_xifu_regfile
    import fir_xifu_pkg::*;
#(
    parameter  int unsigned NB_REGS = NB_REGS_DEFAULT,
    localparam int unsigned IDX_W   = $clog2(NB_REGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [XLEN-1:0]  rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [XLEN-1:0]  rdata_b,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata
);

    logic [XLEN-1:0] regs_q [NB_REGS];

    // Storage: cleared on reset, single write per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NB_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/fir_xifu_ex.sv
// FIR XIFU execute stage: runs committed xfirlw/xfirsw/xfirdotp, owns the register file.
module fir_xifu_ex
    import fir_xifu_pkg::*;
#(
    parameter int unsigned NB_REGS = NB_REGS_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  id2ex_t                            id2ex_i,
    input  ctrl2ex_t                          ctrl2ex_i,
    cv32e40x_if_xif.coproc_mem                xif_mem_o,
    cv32e40x_if_xif.coproc_mem_result         xif_mem_result_i,
    cv32e40x_if_xif.coproc_result             xif_result_o,
    output ex2ctrl_t                          ex2ctrl_o,
    output logic                              ready_o
);

    localparam int unsigned IDX_W = $clog2(NB_REGS);

    ex_state_t       state_q;
    logic            mem_valid_q;
    x_mem_req_t      mem_req_q;
    logic            result_valid_q;
    x_result_t       result_q;
    // Dot-product accumulate is split: lane products latched at commit,
    // accumulator xreg[rd] read and written back in the first RESULT cycle.
    logic            dotp_pend_q;
    logic [XLEN-1:0] dotp_prod_q;

    logic             instr_valid_c;
    logic             is_dotp_c;
    logic             is_lw_c;
    logic             is_sw_c;
    logic             start_c;
    logic             mem_match_c;
    logic             retire_c;
    logic [XLEN-1:0]  store_wdata_c;
    logic [IDX_W-1:0] rf_raddr_a_c;
    logic [IDX_W-1:0] rf_raddr_b_c;
    logic [XLEN-1:0]  rf_rdata_a_c;
    logic [XLEN-1:0]  rf_rdata_b_c;
    logic             rf_we_c;
    logic [XLEN-1:0]  rf_wdata_c;

    // Instruction decode and event qualification.
    assign instr_valid_c = (id2ex_i.instr != INSTR_INVALID);
    assign is_dotp_c     = (id2ex_i.instr == INSTR_XFIRDOTP);
    assign is_lw_c       = (id2ex_i.instr == INSTR_XFIRLW);
    assign is_sw_c       = (id2ex_i.instr == INSTR_XFIRSW);
    assign start_c       = (state_q == EX_IDLE) && instr_valid_c &&
                           ctrl2ex_i.commit && !ctrl2ex_i.kill;
    assign mem_match_c   = (state_q == EX_MEM_WAIT) && xif_mem_result_i.mem_result_valid &&
                           (xif_mem_result_i.mem_result.id == id2ex_i.id);
    assign retire_c      = (state_q == EX_RESULT) && xif_result_o.result_ready;

    // Decode may advance on a bubble, a kill, or the result handshake.
    assign ready_o = ((state_q == EX_IDLE) && (!instr_valid_c || ctrl2ex_i.kill)) || retire_c;

    // Retire notification to the scoreboard, zero payload when idle.
    always_comb begin
        ex2ctrl_o = '0;
        if (retire_c) begin
            ex2ctrl_o.retire = 1'b1;
            ex2ctrl_o.id     = id2ex_i.id;
        end
    end

    // Register file ports; port A reads the accumulator while the dot-product write is pending.
    assign rf_raddr_a_c = (state_q == EX_RESULT && dotp_pend_q) ? id2ex_i.rd[IDX_W-1:0]
                                                                 : id2ex_i.rs1[IDX_W-1:0];
    assign rf_raddr_b_c = id2ex_i.rs2[IDX_W-1:0];
    assign rf_we_c      = !clear_i && ((state_q == EX_RESULT && dotp_pend_q) ||
                                       (mem_match_c && is_lw_c));
    assign rf_wdata_c   = dotp_pend_q ? (rf_rdata_a_c + dotp_prod_q)
                                      : xif_mem_result_i.mem_result.rdata;

    // Store data: arithmetic right shift, amount carried in the rd field.
    assign store_wdata_c = XLEN'($signed(rf_rdata_b_c) >>> id2ex_i.rd[4:0]);

    fir_xifu_regfile #(
        .NB_REGS (NB_REGS)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raddr_a (rf_raddr_a_c),
        .rdata_a (rf_rdata_a_c),
        .raddr_b (rf_raddr_b_c),
        .rdata_b (rf_rdata_b_c),
        .we      (rf_we_c),
        .waddr   (id2ex_i.rd[IDX_W-1:0]),
        .wdata   (rf_wdata_c)
    );

    // Execute FSM with registered memory request and result channels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= EX_IDLE;
            mem_valid_q    <= 1'b0;
            mem_req_q      <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            dotp_pend_q    <= 1'b0;
            dotp_prod_q    <= '0;
        end else if (clear_i) begin
            state_q        <= EX_IDLE;
            mem_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            dotp_pend_q    <= 1'b0;
        end else begin
            dotp_pend_q <= 1'b0;
            case (state_q)
                EX_IDLE: begin
                    if (start_c) begin
                        if (is_dotp_c) begin
                            state_q        <= EX_RESULT;
                            dotp_pend_q    <= 1'b1;
                            dotp_prod_q    <= dotp_prod(rf_rdata_a_c, rf_rdata_b_c);
                            result_valid_q <= 1'b1;
                            result_q.id    <= id2ex_i.id;
                            result_q.data  <= '0;
                            result_q.rd    <= id2ex_i.rd;
                            result_q.we    <= 1'b0;
                            result_q.exc   <= 1'b0;
                        end else begin
                            state_q         <= EX_MEM_REQ;
                            mem_valid_q     <= 1'b1;
                            mem_req_q.id    <= id2ex_i.id;
                            mem_req_q.addr  <= id2ex_i.base;
                            mem_req_q.we    <= is_sw_c;
                            mem_req_q.be    <= 4'hF;
                            mem_req_q.wdata <= store_wdata_c;
                        end
                    end
                end
                EX_MEM_REQ: begin
                    if (xif_mem_o.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if (xif_mem_o.mem_resp.exc) begin
                            state_q        <= EX_RESULT;
                            result_valid_q <= 1'b1;
                            result_q.id    <= id2ex_i.id;
                            result_q.data  <= '0;
                            result_q.rd    <= id2ex_i.rs1;
                            result_q.we    <= 1'b0;
                            result_q.exc   <= 1'b1;
                        end else begin
                            state_q <= EX_MEM_WAIT;
                        end
                    end
                end
                EX_MEM_WAIT: begin
                    if (mem_match_c) begin
                        state_q        <= EX_RESULT;
                        result_valid_q <= 1'b1;
                        result_q.id    <= id2ex_i.id;
                        result_q.data  <= id2ex_i.base + id2ex_i.offset;
                        result_q.rd    <= id2ex_i.rs1;
                        result_q.we    <= 1'b1;
                        result_q.exc   <= 1'b0;
                    end
                end
                EX_RESULT: begin
                    if (xif_result_o.result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= EX_IDLE;
                    end
                end
                default: state_q <= EX_IDLE;
            endcase
        end
    end

    assign xif_mem_o.mem_valid       = mem_valid_q;
    assign xif_mem_o.mem_req         = mem_req_q;
    assign xif_result_o.result_valid = result_valid_q;
    assign xif_result_o.result       = result_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Directed bench for fir_xifu_ex: vector table plus hand-written corner sequences.
module tb_fir_xifu_ex;
    import fir_xifu_pkg::*;

    logic     clk = 1'b0;
    logic     rst_i;
    logic     clear_i;
    id2ex_t   id2ex;
    ctrl2ex_t ctrl2ex;
    ex2ctrl_t ex2ctrl;
    logic     ready;

    cv32e40x_if_xif xif ();

    fir_xifu_ex #(.NB_REGS(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .clear_i          (clear_i),
        .id2ex_i          (id2ex),
        .ctrl2ex_i        (ctrl2ex),
        .xif_mem_o        (xif),
        .xif_mem_result_i (xif),
        .xif_result_o     (xif),
        .ex2ctrl_o        (ex2ctrl),
        .ready_o          (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        instr_t      instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] base;
        logic [31:0] offset;
        logic [31:0] rdata;
        int unsigned dly;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic        e_we;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input instr_t i, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] base,
                                input logic [31:0] off, input logic [31:0] rdata,
                                input int unsigned dly, input logic [31:0] e_wdata,
                                input logic [31:0] e_data, input logic e_we);
        vec_t v;
        v.instr = i; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.base = base; v.offset = off; v.rdata = rdata; v.dly = dly;
        v.e_wdata = e_wdata; v.e_data = e_data; v.e_we = e_we;
        return v;
    endfunction

    task automatic drive_instr(input vec_t v, input logic [3:0] id);
        id2ex.instr  = v.instr;
        id2ex.base   = v.base;
        id2ex.offset = v.offset;
        id2ex.rs1    = v.rs1;
        id2ex.rs2    = v.rs2;
        id2ex.rd     = v.rd;
        id2ex.id     = id;
    endtask

    // Full committed instruction: commit, memory phase (if any), result handshake.
    task automatic run_instr(input string tag, input vec_t v, input logic [3:0] id);
        @(negedge clk);
        drive_instr(v, id);
        ctrl2ex.commit = 1'b1;
        ctrl2ex.kill   = 1'b0;
        #1 chk({tag, ".ready_wait"}, 32'(ready), 32'd0);
        @(posedge clk); @(negedge clk);
        ctrl2ex.commit = 1'b0;
        if (v.instr != INSTR_XFIRDOTP) begin
            for (int k = 0; k <= int'(v.dly); k++) begin
                xif.mem_ready    = (k == int'(v.dly));
                xif.mem_resp.exc = 1'b0;
                #1;
                chk({tag, ".mem_valid"}, 32'(xif.mem_valid), 32'd1);
                chk({tag, ".addr"}, xif.mem_req.addr, v.base);
                chk({tag, ".mem_we"}, 32'(xif.mem_req.we), 32'(v.instr == INSTR_XFIRSW));
                chk({tag, ".be"}, 32'(xif.mem_req.be), 32'hF);
                chk({tag, ".mem_id"}, 32'(xif.mem_req.id), 32'(id));
                if (v.instr == INSTR_XFIRSW) chk({tag, ".wdata"}, xif.mem_req.wdata, v.e_wdata);
                chk({tag, ".ready_memreq"}, 32'(ready), 32'd0);
                @(posedge clk); @(negedge clk);
            end
            xif.mem_ready              = 1'b0;
            xif.mem_result_valid       = 1'b1;
            xif.mem_result.id          = id ^ 4'h1;
            xif.mem_result.rdata       = 32'h0BAD_BAD0;
            #1;
            chk({tag, ".mem_valid_drop"}, 32'(xif.mem_valid), 32'd0);
            chk({tag, ".ready_memwait"}, 32'(ready), 32'd0);
            @(posedge clk); @(negedge clk);
            xif.mem_result.id    = id;
            xif.mem_result.rdata = v.rdata;
            #1 chk({tag, ".wrong_id_ignored"}, 32'(xif.result_valid), 32'd0);
            @(posedge clk); @(negedge clk);
            xif.mem_result_valid = 1'b0;
        end
        #1;
        chk({tag, ".result_valid"}, 32'(xif.result_valid), 32'd1);
        chk({tag, ".res_id"}, 32'(xif.result.id), 32'(id));
        chk({tag, ".res_we"}, 32'(xif.result.we), 32'(v.e_we));
        chk({tag, ".res_exc"}, 32'(xif.result.exc), 32'd0);
        if (v.instr != INSTR_XFIRDOTP) begin
            chk({tag, ".res_rd"}, 32'(xif.result.rd), 32'(v.rs1));
            chk({tag, ".res_data"}, xif.result.data, v.e_data);
        end
        chk({tag, ".retire_early"}, 32'(ex2ctrl.retire), 32'd0);
        xif.result_ready = 1'b1;
        #1;
        chk({tag, ".ready_pulse"}, 32'(ready), 32'd1);
        chk({tag, ".retire"}, 32'(ex2ctrl.retire), 32'd1);
        chk({tag, ".retire_id"}, 32'(ex2ctrl.id), 32'(id));
        @(posedge clk); @(negedge clk);
        xif.result_ready = 1'b0;
        id2ex = '0;
        #1;
        chk({tag, ".result_drop"}, 32'(xif.result_valid), 32'd0);
        chk({tag, ".ready_idle"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_i   = 1'b1;
        clear_i = 1'b0;
        id2ex   = '0;
        ctrl2ex = '0;
        xif.mem_ready        = 1'b0;
        xif.mem_resp         = '0;
        xif.mem_result_valid = 1'b0;
        xif.mem_result       = '0;
        xif.result_ready     = 1'b0;

        //            instr           rs1 rs2 rd  base          offset        rdata         dly e_wdata       e_data        we
        tbl[0]  = mk(INSTR_XFIRLW,   10, 0,  1,  32'h0000_0100, 32'h0,        32'h0003_FFFE, 0, 32'h0,        32'h0000_0100, 1);
        tbl[1]  = mk(INSTR_XFIRLW,   11, 0,  2,  32'h0000_0104, 32'h4,        32'h0002_0005, 1, 32'h0,        32'h0000_0108, 1);
        tbl[2]  = mk(INSTR_XFIRLW,   12, 0,  3,  32'h0000_0200, 32'hFFFF_FFFC, 32'h0000_000A, 0, 32'h0,       32'h0000_01FC, 1);
        tbl[3]  = mk(INSTR_XFIRDOTP, 1,  2,  3,  32'h0,         32'h0,        32'h0,         0, 32'h0,        32'h0,         0);
        tbl[4]  = mk(INSTR_XFIRSW,   13, 3,  0,  32'h0000_0300, 32'h0,        32'h0,         0, 32'h0000_0006, 32'h0000_0300, 1);
        tbl[5]  = mk(INSTR_XFIRLW,   10, 0,  4,  32'h0000_1000, 32'h8,        32'hDEAD_BEEF, 3, 32'h0,        32'h0000_1008, 1);
        tbl[6]  = mk(INSTR_XFIRSW,   14, 4,  0,  32'h0000_0304, 32'h0,        32'h0,         0, 32'hDEAD_BEEF, 32'h0000_0304, 1);
        tbl[7]  = mk(INSTR_XFIRLW,   15, 0,  5,  32'h0000_0040, 32'h0,        32'h8000_0000, 2, 32'h0,        32'h0000_0040, 1);
        tbl[8]  = mk(INSTR_XFIRSW,   16, 5,  4,  32'h0000_2000, 32'hFFFF_FFFC, 32'h0,        1, 32'hF800_0000, 32'h0000_1FFC, 1);
        tbl[9]  = mk(INSTR_XFIRSW,   17, 5,  31, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0,        0, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        tbl[10] = mk(INSTR_XFIRLW,   18, 0,  0,  32'h0000_0050, 32'h0,        32'h7FFF_8000, 0, 32'h0,        32'h0000_0050, 1);
        tbl[11] = mk(INSTR_XFIRDOTP, 0,  0,  0,  32'h0,         32'h0,        32'h0,         0, 32'h0,        32'h0,         0);
        tbl[12] = mk(INSTR_XFIRSW,   19, 0,  0,  32'h0000_0060, 32'h0,        32'h0,         0, 32'hFFFE_8001, 32'h0000_0060, 1);
        tbl[13] = mk(INSTR_XFIRSW,   20, 1,  1,  32'h0000_0070, 32'h0,        32'h0,         0, 32'h0001_FFFF, 32'h0000_0070, 1);
        tbl[14] = mk(INSTR_XFIRDOTP, 1,  2,  2,  32'h0,         32'h0,        32'h0,         0, 32'h0,        32'h0,         0);
        tbl[15] = mk(INSTR_XFIRSW,   21, 2,  16, 32'h0000_0074, 32'h0,        32'h0,         0, 32'h0000_0002, 32'h0000_0074, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.mem_valid", 32'(xif.mem_valid), 32'd0);
        chk("rst.result_valid", 32'(xif.result_valid), 32'd0);
        chk("rst.ex2ctrl", 32'(ex2ctrl), 32'd0);
        chk("rst.mem_addr", xif.mem_req.addr, 32'd0);
        chk("rst.res_data", xif.result.data, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_instr($sformatf("vec%0d", i), tbl[i], 4'(i));
        end

        // Uncommitted instruction waits, then is killed: no effect on xreg3.
        @(negedge clk);
        drive_instr(mk(INSTR_XFIRDOTP, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0), 4'd5);
        ctrl2ex = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("wait%0d.ready", c), 32'(ready), 32'd0);
            chk($sformatf("wait%0d.mem_valid", c), 32'(xif.mem_valid), 32'd0);
            chk($sformatf("wait%0d.result_valid", c), 32'(xif.result_valid), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        ctrl2ex.kill = 1'b1;
        #1 chk("kill.ready", 32'(ready), 32'd1);
        @(posedge clk); @(negedge clk);
        ctrl2ex = '0;
        id2ex   = '0;
        #1;
        chk("kill.no_result", 32'(xif.result_valid), 32'd0);
        chk("kill.no_mem", 32'(xif.mem_valid), 32'd0);
        chk("kill.ready_after", 32'(ready), 32'd1);

        // Commit and kill together: kill wins.
        @(negedge clk);
        drive_instr(mk(INSTR_XFIRDOTP, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0), 4'd6);
        ctrl2ex.commit = 1'b1;
        ctrl2ex.kill   = 1'b1;
        #1 chk("ckill.ready", 32'(ready), 32'd1);
        @(posedge clk); @(negedge clk);
        ctrl2ex = '0;
        id2ex   = '0;
        #1;
        chk("ckill.no_result", 32'(xif.result_valid), 32'd0);
        chk("ckill.no_mem", 32'(xif.mem_valid), 32'd0);
        run_instr("kill_x3", mk(INSTR_XFIRSW, 22, 3, 0, 32'h400, 0, 0, 0, 32'h6, 32'h400, 1), 4'd7);

        // Memory exception on a load: no write, result flags exception.
        @(negedge clk);
        drive_instr(mk(INSTR_XFIRLW, 10, 0, 4, 32'h3000, 0, 0, 0, 0, 0, 0), 4'd9);
        ctrl2ex.commit = 1'b1;
        @(posedge clk); @(negedge clk);
        ctrl2ex.commit   = 1'b0;
        xif.mem_ready    = 1'b1;
        xif.mem_resp.exc = 1'b1;
        #1 chk("exc.mem_valid", 32'(xif.mem_valid), 32'd1);
        @(posedge clk); @(negedge clk);
        xif.mem_ready    = 1'b0;
        xif.mem_resp.exc = 1'b0;
        #1;
        chk("exc.mem_drop", 32'(xif.mem_valid), 32'd0);
        chk("exc.result_valid", 32'(xif.result_valid), 32'd1);
        chk("exc.res_exc", 32'(xif.result.exc), 32'd1);
        chk("exc.res_we", 32'(xif.result.we), 32'd0);
        chk("exc.res_id", 32'(xif.result.id), 32'd9);
        xif.result_ready = 1'b1;
        #1 chk("exc.retire", 32'(ex2ctrl.retire), 32'd1);
        @(posedge clk); @(negedge clk);
        xif.result_ready = 1'b0;
        id2ex = '0;
        #1 chk("exc.result_drop", 32'(xif.result_valid), 32'd0);
        run_instr("exc_x4", mk(INSTR_XFIRSW, 23, 4, 0, 32'h404, 0, 0, 0, 32'hDEAD_BEEF, 32'h404, 1), 4'd10);

        // Clear during MEM_WAIT; a late matching result must be ignored.
        @(negedge clk);
        drive_instr(mk(INSTR_XFIRLW, 10, 0, 4, 32'h3100, 0, 0, 0, 0, 0, 0), 4'd8);
        ctrl2ex.commit = 1'b1;
        @(posedge clk); @(negedge clk);
        ctrl2ex.commit = 1'b0;
        xif.mem_ready  = 1'b1;
        #1 chk("clr.mem_valid", 32'(xif.mem_valid), 32'd1);
        @(posedge clk); @(negedge clk);
        xif.mem_ready = 1'b0;
        clear_i       = 1'b1;
        #1 chk("clr.ready_memwait", 32'(ready), 32'd0);
        @(posedge clk); @(negedge clk);
        clear_i              = 1'b0;
        id2ex                = '0;
        xif.mem_result_valid = 1'b1;
        xif.mem_result.id    = 4'd8;
        xif.mem_result.rdata = 32'h1234_5678;
        #1;
        chk("clr.idle_ready", 32'(ready), 32'd1);
        chk("clr.mem_valid_low", 32'(xif.mem_valid), 32'd0);
        chk("clr.result_low", 32'(xif.result_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        xif.mem_result_valid = 1'b0;
        #1 chk("clr.late_ignored", 32'(xif.result_valid), 32'd0);
        run_instr("clr_x4", mk(INSTR_XFIRSW, 24, 4, 0, 32'h408, 0, 0, 0, 32'hDEAD_BEEF, 32'h408, 1), 4'd11);

        // Reset clears the register file.
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        #1 chk("rst2.ready", 32'(ready), 32'd1);
        run_instr("rst_x4", mk(INSTR_XFIRSW, 25, 4, 0, 32'h40C, 0, 0, 0, 32'h0, 32'h40C, 1), 4'd12);
        run_instr("rst_x3", mk(INSTR_XFIRSW, 26, 3, 0, 32'h410, 0, 0, 0, 32'h0, 32'h410, 1), 4'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
